// File: rtl/mem_access_unit.sv
// Load/store unit: one word-wide req/ack transaction per request, store formatting, load extension.
// Optional `MEM_ACCESS_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses as illegal.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // Pipeline request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // Pipeline response
  output logic        resp_valid,
  output logic        err,
  output logic [31:0] dm_rd,
  output logic        busy,
  // Data-memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  // Counter only needs to reach MAX_WAIT-1; the timeout fires on the following edge.
  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CntW-1:0] wait_q;

  logic        f3_ok;
  logic        misaligned;
  logic        req_legal;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_ext;

  assign req_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      F3Byte, F3Half, F3Word: f3_ok = 1'b1;
      F3ByteU, F3HalfU:       f3_ok = !req_we;
      default:                f3_ok = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_legal = f3_ok && !misaligned;

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          fmt_be    = 4'b0001 << req_addr[1:0];
          fmt_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          fmt_be    = 4'b0011 << {req_addr[1], 1'b0};
          fmt_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          fmt_be    = 4'b1111;
          fmt_wdata = req_wdata;
        end
      endcase
    end
  end

  assign byte_sh = mem_rdata >> {off_q, 3'b000};
  assign half_sh = mem_rdata >> {off_q[1], 4'b0000};

  always_comb begin
    load_ext = mem_rdata;
    case (f3_q)
      F3Byte:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3Half:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      F3ByteU: load_ext = {24'h0, byte_sh[7:0]};
      F3HalfU: load_ext = {16'h0, half_sh[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      wait_q     <= '0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      dm_rd      <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
            if (req_legal) begin
              state_q   <= StAccess;
              wait_q    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= fmt_wdata;
              mem_be    <= fmt_be;
            end else begin
              // Illegal access: skip the memory and report straight away.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              dm_rd      <= 32'h0;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            if (!we_q) dm_rd <= load_ext;
          end else if (wait_q == CntLast) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            if (!we_q) dm_rd <= 32'h0;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          err        <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses queued at request time, popped on resp_valid.
module tb_mem_access_unit;

  localparam int unsigned MaxWait = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        err;
  logic [31:0] dm_rd;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .err       (err),
    .dm_rd     (dm_rd),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_resp = 0;
  logic [31:0] last_dm = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: every resp_valid cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", 32'(err), 32'(mon_e.err));
        check("resp_dm_rd", dm_rd, mon_e.dm);
      end
    end
  end

  // delay < 0 means the memory never acknowledges.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                        input logic [31:0] rdata, input logic exp_err, input logic [31:0] exp_dm,
                        input logic exp_mem, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int   resp_before;
    int   cnt;
    int   waited;
    logic stable;
    exp_t e;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    resp_before = n_resp;
    e.err = exp_err;
    e.dm  = exp_dm;
    exp_q.push_back(e);
    last_dm    = exp_dm;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_mem) begin
      check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
      check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
      if (we) check({tag, "_mem_wdata"}, mem_wdata, exp_wd);
      cnt    = 0;
      stable = 1'b1;
      if (delay >= 0) begin
        for (int i = 0; i <= delay; i++) begin
          if (mem_req) cnt++;
          if (mem_addr != {addr[31:2], 2'b00} || mem_be != exp_be) stable = 1'b0;
          if (i == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
          end
          @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, "_req_cycles"}, 32'(cnt), 32'(delay + 1));
      end else begin
        for (int i = 0; i < int'(MaxWait) + 4; i++) begin
          if (!mem_req) break;
          cnt++;
          if (mem_addr != {addr[31:2], 2'b00} || mem_be != exp_be) stable = 1'b0;
          @(negedge clk);
        end
        check({tag, "_timeout_cycles"}, 32'(cnt), 32'(MaxWait));
      end
      check({tag, "_stable"}, 32'(stable), 32'd1);
    end
    check({tag, "_mem_req_low"}, 32'(mem_req), 32'd0);
    check({tag, "_busy_resp"}, 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check({tag, "_resp_pulses"}, 32'(n_resp - resp_before), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int resp_before;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_dm_rd", dm_rd, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    do_req("sb", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, 1'b0, last_dm,
           1'b1, 4'b1000, 32'hA5A5_A5A5);
    do_req("sh", 1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 2, 32'h0, 1'b0, last_dm,
           1'b1, 4'b1100, 32'hBEEF_BEEF);
    do_req("sw", 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, last_dm,
           1'b1, 4'b1111, 32'hDEAD_BEEF);
    do_req("lb", 1'b0, 3'b000, 32'h0000_2002, 32'h0, 0, 32'h0080_FF11, 1'b0, 32'hFFFF_FF80,
           1'b1, 4'b1111, 32'h0);
    do_req("lbu", 1'b0, 3'b100, 32'h0000_2002, 32'h0, 0, 32'h0080_FF11, 1'b0, 32'h0000_0080,
           1'b1, 4'b1111, 32'h0);
    do_req("lh", 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5, 32'h8001_1234, 1'b0, 32'hFFFF_8001,
           1'b1, 4'b1111, 32'h0);
    do_req("lhu", 1'b0, 3'b101, 32'h0000_2000, 32'h0, 1, 32'h8001_F234, 1'b0, 32'h0000_F234,
           1'b1, 4'b1111, 32'h0);
    do_req("sb_keep", 1'b1, 3'b000, 32'h0000_1000, 32'h0000_007F, 0, 32'h0, 1'b0, last_dm,
           1'b1, 4'b0001, 32'h7F7F_7F7F);
    do_req("ill_ld", 1'b0, 3'b011, 32'h0000_2000, 32'h0, 0, 32'h0, 1'b1, 32'h0,
           1'b0, 4'b0000, 32'h0);
    do_req("ill_st", 1'b1, 3'b100, 32'h0000_2000, 32'h0, 0, 32'h0, 1'b1, 32'h0,
           1'b0, 4'b0000, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    do_req("lw_mis", 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 32'h0,
           1'b0, 4'b0000, 32'h0);
`else
    do_req("lw_mis", 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D,
           1'b1, 4'b1111, 32'h0);
`endif
    do_req("lw", 1'b0, 3'b010, 32'h0000_3000, 32'h0, 3, 32'h1122_3344, 1'b0, 32'h1122_3344,
           1'b1, 4'b1111, 32'h0);
    do_req("to_st", 1'b1, 3'b010, 32'h0000_3008, 32'h5555_AAAA, -1, 32'h0, 1'b1, last_dm,
           1'b1, 4'b1111, 32'h5555_AAAA);
    do_req("to_ld", 1'b0, 3'b010, 32'h0000_300C, 32'h0, -1, 32'h0, 1'b1, 32'h0,
           1'b1, 4'b1111, 32'h0);

    // Stray ack while idle must not start anything or disturb dm_rd.
    resp_before = n_resp;
    mem_ack     = 1'b1;
    mem_rdata   = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_dm_rd", dm_rd, 32'd0);
    @(negedge clk);
    #1;
    check("stray_no_resp", 32'(n_resp - resp_before), 32'd0);

    // Reset while a load is in ACCESS: no response, everything back to idle.
    do_req("pre_rst", 1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE,
           1'b1, 4'b1111, 32'h0);
    resp_before = n_resp;
    req_valid   = 1'b1;
    req_we      = 1'b0;
    req_funct3  = 3'b010;
    req_addr    = 32'h0000_4004;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("acc_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dm_rd", dm_rd, 32'd0);
    rst = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("arst_no_resp", 32'(n_resp - resp_before), 32'd0);
    last_dm = 32'h0;

    do_req("post_rst", 1'b0, 3'b000, 32'h0000_5001, 32'h0, 0, 32'h0000_7F00, 1'b0, 32'h0000_007F,
           1'b1, 4'b1111, 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Load/store stage directly upstream of the register-file write-back select.
- Accepts one load/store request from the pipeline and runs one word-wide transaction on the data-memory port using a req/ack handshake.
- Forms byte enables and replicates store data for byte and halfword stores.
- Extracts and sign- or zero-extends load data; the result is `dm_rd`, the memory-output source of the write-back mux.
- Asserts `busy` to stall the pipeline while a request is in flight.

## Interface
- `MAX_WAIT`, default 255: cycles in ACCESS without `mem_ack` before the transaction is abandoned with an error.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: pipeline request strobe.
- `req_ready` out 1: request is accepted at the edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: access type.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `resp_valid` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `resp_valid`; the access failed.
- `dm_rd` out 32: extended load data. Holds its value between responses.
- `busy` out 1: high whenever state is not IDLE.
- `mem_req` out 1: memory request, held high until acknowledged.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2], 2'b00}`.
- `mem_wdata` out 32: store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: memory completion. Read data is valid in the same cycle.
- `mem_rdata` in 32: memory read word.

## Operation
**States**
- IDLE
  - `req_ready` = 1 (forced to 0 while `rst` is high).
  - On accept: latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
  - Next state is ACCESS, or RESP with error if the request is illegal.
- ACCESS
  - `mem_req` = 1. `mem_we`, `mem_addr`, `mem_wdata`, `mem_be` come from the latched request and are stable throughout.
  - On `mem_ack`: capture the extended load data (loads only) and go to RESP.
- RESP
  - `resp_valid` = 1 for exactly one cycle, then IDLE.
  - `req_ready` = 0.

**Store formatting** (`o = addr[1:0]`)
- SB: `be = 4'b0001 << o`; `wdata = {4{rs2[7:0]}}`.
- SH: `be = 4'b0011 << (2*addr[1])`; `wdata = {2{rs2[15:0]}}`.
- SW: `be = 4'b1111`; `wdata = rs2`.
- Loads: `be = 4'b1111`, `mem_we = 0`.

**Load extraction**
- Byte = `mem_rdata >> (8*o)`; halfword = `mem_rdata >> (16*addr[1])`.
- LB and LH sign-extend to 32 bits; LBU and LHU zero-extend; LW passes the word through.
- Stores leave `dm_rd` unchanged.

**Errors**
- Illegal `funct3` (including 011, 110, 111, and loads/stores outside the list above): no memory transaction. Go to RESP with `err` = 1 and `dm_rd` = 0.
- Timeout: the ACCESS cycle counter reaches `MAX_WAIT` without `mem_ack`.
  - Drop `mem_req` and go to RESP with `err` = 1.
  - `dm_rd` = 0 for loads; unchanged for stores.
- `mem_ack` is ignored outside ACCESS, including a late ack after a timeout.

## Timing
- Reset values: state IDLE; `dm_rd` = 0; `resp_valid`, `err`, `mem_req`, `mem_we`, `busy` = 0; `mem_addr`, `mem_wdata`, `mem_be` = 0; wait counter = 0.
- Accept at edge T0. `mem_req` is high from T0 until the edge at which `mem_ack` is sampled (edge T1 for a zero-wait memory).
- `resp_valid` and `dm_rd` become valid right after the ack edge. `resp_valid` is high for one cycle.
- Zero-wait throughput is one request per 3 cycles, because `req_ready` is low in both ACCESS and RESP.
- The wait counter clears on entry to ACCESS. Timeout fires on the edge after `MAX_WAIT` cycles with `mem_ack` low.
- `rst` asserted in any state returns to IDLE at the next edge. `mem_req` drops at that edge, and any in-flight response is discarded with no `resp_valid`.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.
- When defined:
  - LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` ≠ 0, is treated as illegal.
  - No memory transaction is issued; the response is `err` = 1 with `dm_rd` = 0.
- When undefined:
  - Low address bits beyond the access alignment are ignored. Halfword accesses use only `addr[1]`; word accesses use only `addr[31:2]`.
  - No error is raised.

## Test plan
- SB, rs2 = 0x000000A5, addr = 0x1003, ack on first cycle:
  - `mem_be` = 1000, `mem_wdata` = 0xA5A5A5A5, `mem_addr` = 0x1000.
  - `resp_valid` pulses one cycle, `err` = 0.
- LB then LBU at addr 0x2002 with `mem_rdata` = 0x0080FF11:
  - LB gives `dm_rd` = 0xFFFFFF80.
  - LBU gives `dm_rd` = 0x00000080.
- LH at addr 0x2002 with ack delayed 5 cycles and `mem_rdata` = 0x8001_1234:
  - `mem_req` is held 6 cycles with stable address/`be`.
  - `dm_rd` = 0xFFFF8001.
- Memory never acks, `MAX_WAIT` = 8:
  - `mem_req` drops after 8 cycles; `resp_valid` and `err` = 1.
  - A later stray `mem_ack` is ignored.
- LW at addr 0x3002:
  - Macro defined: `err` = 1, `mem_req` never rises.
  - Macro undefined: `mem_addr` = 0x3000, `dm_rd` = `mem_rdata`.
- `rst` pulsed during ACCESS: next cycle `mem_req` = 0, `busy` = 0, `dm_rd` = 0, `req_ready` = 1, and no `resp_valid` occurs.
